// File: rtl/ov7670_sccb_config_if.sv
// Signal bundle between the OV7670 SCCB configuration sequencer, its register ROM,
// the SCCB pins and the capture-side start/status handshake.
interface ov7670_sccb_config_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              sioc;
    logic              siod_oe;
    logic              busy;
    logic              done;

    modport master (
        input  start, rom_data,
        output rom_addr, sioc, siod_oe, busy, done
    );

    modport slave (
        output start, rom_data,
        input  rom_addr, sioc, siod_oe, busy, done
    );
endinterface

// File: rtl/ov7670_sccb_config.sv
// Walks an external register ROM and writes each entry to the OV7670 over SCCB
// (ID 0x42, reg, value); honours 0xFFF0 delay and 0xFFFF end markers.
module ov7670_sccb_config #(
    parameter int unsigned CLK_DIV      = 125,
    parameter int unsigned POWERUP_WAIT = 50_000,
    parameter int unsigned DELAY_CYCLES = 500_000,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ov7670_sccb_config_if.master bus
);
    localparam int unsigned WAIT_MAX = (POWERUP_WAIT > DELAY_CYCLES) ? POWERUP_WAIT : DELAY_CYCLES;
    localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam logic [7:0]  WRITE_ID = 8'h42;

    typedef enum logic [3:0] {
        S_RESET_IDLE, S_PWR_WAIT, S_FETCH, S_DECODE, S_START,
        S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic [1:0]        qtr_q;
    logic [4:0]        bit_q;
    logic [26:0]       shift_q;
    logic [15:0]       entry_q;
    logic              fetch_q, sioc_q, siod_oe_q, busy_q, done_q;
    logic              qtr_end, pwr_end, dly_end, advance;

    always_comb begin
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        qtr_end    = (div_q == DIV_W'(CLK_DIV - 1));
        pwr_end    = (wait_cnt_q == CNT_W'(POWERUP_WAIT - 1));
        dly_end    = (wait_cnt_q == CNT_W'(DELAY_CYCLES - 1));
        advance    = ((state_q == S_GAP) && qtr_end && (qtr_q == 2'd3)) ||
                     ((state_q == S_DELAY) && dly_end);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_RESET_IDLE;
            rom_addr_q <= '0;
            wait_cnt_q <= '0;
            div_q      <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            entry_q    <= '0;
            fetch_q    <= 1'b0;
            sioc_q     <= 1'b1;
            siod_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            div_q <= qtr_end ? '0 : div_q + DIV_W'(1);
            // GAP and DELAY share one exit path; the index saturates at the last entry.
            if (advance) begin
                if (&rom_addr_q) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    rom_addr_q <= rom_addr_d;
                    fetch_q    <= 1'b0;
                    state_q    <= S_FETCH;
                end
            end else begin
                case (state_q)
                    S_RESET_IDLE: begin
                        state_q    <= S_PWR_WAIT;
                        busy_q     <= 1'b1;
                        wait_cnt_q <= '0;
                    end
                    S_PWR_WAIT: begin
                        if (pwr_end) begin
                            state_q    <= S_FETCH;
                            rom_addr_q <= '0;
                            fetch_q    <= 1'b0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        end
                    end
                    S_FETCH: begin
                        fetch_q <= 1'b1;
                        if (fetch_q) begin
                            entry_q <= bus.rom_data;
                            state_q <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        if (entry_q == 16'hFFFF) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (entry_q == 16'hFFF0) begin
                            state_q    <= S_DELAY;
                            wait_cnt_q <= '0;
                        end else begin
                            state_q   <= S_START;
                            div_q     <= '0;
                            qtr_q     <= '0;
                            sioc_q    <= 1'b1;
                            siod_oe_q <= 1'b0;
                            shift_q   <= {WRITE_ID, 1'b1, entry_q[15:8], 1'b1, entry_q[7:0], 1'b1};
                        end
                    end
                    S_START: begin
                        if (qtr_end) begin
                            if (qtr_q == 2'd0) begin
                                qtr_q     <= 2'd1;
                                siod_oe_q <= 1'b1;
                            end else begin
                                state_q   <= S_BITS;
                                qtr_q     <= 2'd0;
                                bit_q     <= '0;
                                sioc_q    <= 1'b0;
                                siod_oe_q <= ~shift_q[26];
                            end
                        end
                    end
                    S_BITS: begin
                        if (qtr_end) begin
                            qtr_q <= qtr_q + 2'd1;
                            case (qtr_q)
                                2'd1: sioc_q <= 1'b1;
                                2'd3: begin
                                    sioc_q <= 1'b0;
                                    if (bit_q == 5'd26) begin
                                        state_q   <= S_STOP;
                                        siod_oe_q <= 1'b1;
                                    end else begin
                                        bit_q     <= bit_q + 5'd1;
                                        shift_q   <= {shift_q[25:0], 1'b0};
                                        siod_oe_q <= ~shift_q[25];
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_STOP: begin
                        if (qtr_end) begin
                            case (qtr_q)
                                2'd0: begin
                                    sioc_q <= 1'b1;
                                    qtr_q  <= 2'd1;
                                end
                                2'd1: begin
                                    siod_oe_q <= 1'b0;
                                    qtr_q     <= 2'd2;
                                end
                                default: begin
                                    state_q <= S_GAP;
                                    qtr_q   <= 2'd0;
                                end
                            endcase
                        end
                    end
                    S_GAP: begin
                        if (qtr_end) qtr_q <= qtr_q + 2'd1;
                    end
                    S_DELAY: wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    S_DONE: begin
                        if (bus.start) begin
                            state_q    <= S_FETCH;
                            rom_addr_q <= '0;
                            fetch_q    <= 1'b0;
                            done_q     <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                    default: state_q <= S_RESET_IDLE;
                endcase
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.sioc     = sioc_q;
    assign bus.siod_oe  = siod_oe_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Randomised scoreboard bench: a table-walking reference model predicts writes and
// timing; a negedge bus monitor decodes SCCB frames and checks protocol shape.
module tb_ov7670_sccb_config;
    localparam int CD = 4, PW = 16, DC = 32, AW = 2, NENT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0, fails = 0, cyc = 0;
    logic [23:0] expq[$];
    logic [15:0] rom [NENT];

    ov7670_sccb_config_if #(.ADDR_W(AW)) bus ();

    ov7670_sccb_config #(
        .CLK_DIV(CD), .POWERUP_WAIT(PW), .DELAY_CYCLES(DC), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic flag(input string nm, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: observed 0x%0h", nm, act);
    endtask

    function automatic logic [15:0] rnd_w();
        logic [15:0] w;
        do w = 16'($urandom); while (w == 16'hFFFF || w == 16'hFFF0);
        return w;
    endfunction

    // Reference: walk the table, push expected frames, return predicted edge times.
    task automatic model(input int base, output int t_done, output int t_fall, output int fin_addr);
        int t;
        t = base; t_fall = -1; fin_addr = NENT - 1;
        for (int i = 0; i < NENT; i++) begin
            t += 3;
            if (rom[i] == 16'hFFFF) begin
                fin_addr = i;
                break;
            end
            if (rom[i] == 16'hFFF0) t += DC;
            else begin
                if (t_fall < 0) t_fall = t + 2 * CD;
                expq.push_back({8'h42, rom[i]});
                t += 117 * CD;
            end
        end
        t_done = t;
    endtask

    initial begin : monitor
        logic psc, poe, sc, oe, in_tx;
        int bits, tstart, lfall;
        logic [26:0] sh;
        logic [23:0] got;
        psc = 1'b1; poe = 1'b0; in_tx = 1'b0; bits = 0; tstart = 0; lfall = -1; sh = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_tx = 1'b0; psc = 1'b1; poe = 1'b0;
                continue;
            end
            sc = bus.sioc;
            oe = bus.siod_oe;
            if (oe != poe && sc) begin
                if (psc && oe && !in_tx) begin
                    in_tx = 1'b1; bits = 0; tstart = cyc; lfall = -1;
                end else if (psc && !oe && in_tx && bits == 27) begin
                    in_tx = 1'b0;
                    chk("frame length", cyc - tstart, 111 * CD);
                    got = {sh[26:19], sh[17:10], sh[8:1]};
                    if (expq.size() == 0) flag("unexpected write", got);
                    else chk("write bytes", got, expq.pop_front());
                end else begin
                    flag("siod changed while sioc high", {bits[7:0], 6'd0, in_tx, oe});
                end
            end
            if (psc && !sc) begin
                if (!in_tx) flag("sioc fell outside a frame", cyc);
                else begin
                    if (lfall >= 0) chk("sioc period", cyc - lfall, 4 * CD);
                    lfall = cyc;
                end
            end
            if (!psc && sc && in_tx && bits < 27) begin
                sh = {sh[25:0], ~oe};
                bits++;
                if (bits % 9 == 0) chk("9th bit released", oe, 0);
            end
            psc = sc;
            poe = oe;
        end
    end

    task automatic reset_release();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset sioc", bus.sioc, 1);
        chk("reset siod_oe", bus.siod_oe, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset rom_addr", bus.rom_addr, 0);
        reset_n = 1'b1;
    endtask

    task automatic restart();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("restart rom_addr", bus.rom_addr, 0);
        chk("restart done cleared", bus.done, 0);
        chk("restart busy", bus.busy, 1);
    endtask

    task automatic run(input string nm, input int t_done, input int t_fall, input int fin_addr, input int poke);
        int n, tf, td, nidle;
        n = 0; tf = -1; td = -1; nidle = 0;
        while (n < t_done + 64) begin
            @(posedge clk); #1;
            n++;
            bus.start = (n == poke);
            if (!bus.busy && !bus.done) nidle++;
            if (!bus.sioc && tf < 0) tf = n;
            if (bus.done) begin
                td = n;
                break;
            end
        end
        bus.start = 1'b0;
        chk({nm, " done edge"}, td, t_done);
        chk({nm, " first sioc fall"}, tf, t_fall);
        chk({nm, " busy gaps"}, nidle, 0);
        chk({nm, " busy low with done"}, bus.busy, 0);
        chk({nm, " final rom_addr"}, bus.rom_addr, fin_addr);
        chk({nm, " scoreboard drained"}, expq.size(), 0);
        repeat (8) @(posedge clk);
        #1;
        chk({nm, " done held"}, bus.done, 1);
        chk({nm, " rom_addr held"}, bus.rom_addr, fin_addr);
    endtask

    task automatic scenario(input string nm, input logic from_reset, input int poke);
        int td, tf, fa;
        model(from_reset ? 1 + PW : 0, td, tf, fa);
        if (from_reset) reset_release();
        else restart();
        run(nm, td, tf, fa, poke);
    endtask

    initial begin : stim
        int td, tf, fa, target, r;
        bus.start = 1'b0;
        reset_n = 1'b0;

        rom[0] = rnd_w(); rom[1] = 16'hFFFF; rom[2] = rnd_w(); rom[3] = rnd_w();
        scenario("single write", 1'b1, -1);
        scenario("restart ignores busy start", 1'b0, 100);

        rom[0] = 16'hFFF0; rom[1] = rnd_w(); rom[2] = 16'hFFFF; rom[3] = rnd_w();
        scenario("delay entry", 1'b0, -1);

        // Abort inside bit 5 of the register byte of the second frame.
        rom[0] = rnd_w(); rom[1] = rnd_w(); rom[2] = 16'hFFFF; rom[3] = rnd_w();
        model(1 + PW, td, tf, fa);
        reset_release();
        target = (1 + PW + 3 + 117 * CD + 3) + 2 * CD + 14 * 4 * CD + 1;
        repeat (target) @(posedge clk);
        #1;
        chk("pre-abort sioc low", bus.sioc, 0);
        chk("pre-abort rom_addr", bus.rom_addr, 1);
        bus.start = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("abort sioc", bus.sioc, 1);
        chk("abort siod_oe", bus.siod_oe, 0);
        chk("abort rom_addr", bus.rom_addr, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("reset beats start", bus.rom_addr | {1'b0, bus.busy} | {1'b0, bus.done}, 0);
        chk("aborted frame pending", expq.size(), 1);
        expq.delete();
        scenario("after abort", 1'b1, -1);

        for (int i = 0; i < NENT; i++) rom[i] = rnd_w();
        scenario("full table", 1'b0, -1);

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NENT; i++) begin
                r = $urandom_range(0, 9);
                rom[i] = (r == 0) ? 16'hFFFF : (r == 1) ? 16'hFFF0 : rnd_w();
            end
            scenario("random table", logic'(it % 2), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ov7670_sccb_config.md
# ov7670_sccb_config

Sequencer that configures the OV7670 camera over SCCB, the camera's two-wire serial control bus, before the camera starts streaming pixels to the VGA path.
- Walks a register table held in an external synchronous ROM.
- Issues one 3-phase SCCB write per entry and honours in-table delay and end markers.
- Flags completion so downstream capture logic starts only on a configured sensor.
- Sits beside the pixel path; runs on the system clock, not the camera pclk.

## Interface
Parameters:
- CLK_DIV, 125: clk cycles per SCCB quarter-bit (50 MHz → 100 kHz SCCB); minimum 2.
- POWERUP_WAIT, 50_000: cycles idle after reset before the first transaction.
- DELAY_CYCLES, 500_000: cycles waited on a delay entry.
- ADDR_W, 8: ROM address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; reruns the table from entry 0.
- rom_addr  out  ADDR_W  table index; registered.
- rom_data  in  16  {reg_addr[15:8], value[7:0]}; valid 1 clk after rom_addr changes.
- sioc  out  1  SCCB clock; push-pull.
- siod_oe  out  1  1 = pull SIOD low; 0 = release (bus pull-up gives high).
- busy  out  1  sequence in progress.
- done  out  1  table completed; held until the next start or reset.

## Operation
- Reset values: sioc=1, siod_oe=0, busy=0, done=0, rom_addr=0. State is RESET_IDLE.
- States:
  - RESET_IDLE: always advances to PWR_WAIT on the first clk after reset_n is sampled high.
  - PWR_WAIT: counts POWERUP_WAIT cycles, then goes to FETCH.
  - FETCH: rom_addr is set on entry; rom_data is sampled 2 clk after entry.
  - DECODE: dispatches on the sampled entry.
    - 16'hFFFF → DONE.
    - 16'hFFF0 → DELAY.
    - Any other value → START.
  - START, BITS, STOP, GAP: one transaction.
  - DELAY: counts DELAY_CYCLES, then advances to the next entry.
  - DONE: sets done=1 and busy=0. start → PWR_WAIT is skipped; goes directly to FETCH with rom_addr=0 and done cleared.
- busy=1 in every state except RESET_IDLE and DONE.
- Transaction bytes, MSB first: 0x42 (write ID), reg_addr, value. Each byte is followed by a 9th don't-care bit with SIOD released; ACK is not checked.
- Quarter-tick divider restarts on entry to START, so every transaction is quarter-aligned.
- Bus waveform per quarter (Q):
  - START: Q0 sioc=1, siod released; Q1 sioc=1, siod low.
  - Each bit: Q0 sioc=0, siod set; Q1 sioc=0; Q2 sioc=1; Q3 sioc=1.
  - STOP: Q0 sioc=0, siod low; Q1 sioc=1, siod low; Q2 sioc=1, siod released.
  - GAP: 4 quarters, bus idle (sioc=1, siod released).
- SIOD changes only while sioc=0, except at START Q1 and STOP Q2.
- Advance after GAP or DELAY: rom_addr+1. If rom_addr was 2^ADDR_W−1, go to DONE instead; the index never wraps.
- start while busy=1 is ignored.

## Timing
- One transaction = 2 + 27×4 + 3 = 113 quarters = 113×CLK_DIV clk.
- GAP adds 4×CLK_DIV clk.
- Entry overhead (FETCH+DECODE) = 3 clk.
- start → first rom_addr drive: 1 clk.
- done and busy change on the same edge.
- reset_n low mid-transaction:
  - Outputs take reset values immediately, combinationally through the async reset.
  - The camera resynchronises on the next START.
- reset_n asserted and start pulsed together: reset wins.

## Test plan
Bench parameters: CLK_DIV=4, POWERUP_WAIT=16, DELAY_CYCLES=32, ROM modelled with 1-clk latency.
- ROM {0x1280, 0xFFFF}, release reset:
  - busy=1 from the 2nd clk after release.
  - First sioc fall after 16+3 clk of idle.
  - Bus monitor decodes 0x42, 0x12, 0x80.
  - Transaction lasts 452 clk.
  - done=1 and busy=0 after GAP plus 3 clk.
- ROM {0xFFF0, 0x1101, 0xFFFF}:
  - Bus stays idle (sioc=1, siod_oe=0) for 32 clk plus overhead.
  - Then one write 0x42/0x11/0x01, then done.
- Pulse start mid-transaction → ignored; no glitch on the bus. Pulse start after done → done falls, rom_addr=0, identical bus sequence repeats, no power-up wait.
- Assert reset_n low at bit 5 of the second byte:
  - Same cycle: sioc=1, siod_oe=0, rom_addr=0, busy=0.
  - After release, the full sequence restarts with the power-up wait.
- ADDR_W=2, ROM with no 0xFFFF (4 valid entries) → exactly 4 transactions, then done=1, rom_addr stays 3.
- Protocol checker over all scenarios:
  - SIOD never changes while sioc=1, except at START and STOP.
  - Every 9th bit has siod_oe=0.
  - sioc period = 4×CLK_DIV clk.
